// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter: two-master round-robin arbiter and byte-serial sequencer
// for the external memory bus. One transaction walks IDLE -> ADDR -> CMD ->
// DATA -> DONE, moving one byte per cycle over the 8-bit pins.
// Optional build macro: EXT_BUS_WAIT_EN adds a bus_wait input that stalls
// the DATA phase while high.
module ext_bus_arbiter #(
  parameter int ADDR_BYTES = 8,
  parameter int DATA_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [8*ADDR_BYTES-1:0] addr0,
  input  logic [8*ADDR_BYTES-1:0] addr1,
  input  logic [8*DATA_BYTES-1:0] wdata0,
  input  logic [8*DATA_BYTES-1:0] wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    busy,
  output logic [7:0]              addr_o,
  output logic [7:0]              dat_o,
  output logic [7:0]              dat_oe,
  input  logic [7:0]              dat_i
`ifdef EXT_BUS_WAIT_EN
  ,
  input  logic                    bus_wait
`endif
);

  localparam int AW   = 8 * ADDR_BYTES;
  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_DATA,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // beat counter, cleared on every phase entry
  logic          gnt_q, gnt_d;     // requester owning the current transaction
  logic          last_q, last_d;   // last winner, drives round-robin priority
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          stall;
  logic          win;
  logic [7:0]    addr_byte;
  logic [7:0]    wdata_byte;
  logic [CW+2:0] byte_sh;

`ifdef EXT_BUS_WAIT_EN
  assign stall = bus_wait;
`else
  assign stall = 1'b0;
`endif

  // Current beat's bytes; write bytes past the end of wdata shift out as zero.
  assign byte_sh    = {cnt_q, 3'b000};
  assign addr_byte  = 8'(addr_q >> byte_sh);
  assign wdata_byte = 8'(wdata_q >> byte_sh);

  // Arbitration: a lone request wins; on contention the non-last winner wins.
  assign win = (req0 && req1) ? ~last_q : req1;

  // Next-state, beat counting, request latching and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = win;
          last_d  = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_d   = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cnt_q == ADDR_LAST) begin
          cnt_d   = '0;
          state_d = S_CMD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CMD: begin
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (!stall) begin
          if (!we_q) begin
            rdata_d = (rdata_q & ~(DW'(8'hFF) << byte_sh)) | (DW'(dat_i) << byte_sh);
          end
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from registered state and latched request.
  always_comb begin
    busy   = (state_q != S_IDLE);
    ack0   = 1'b0;
    ack1   = 1'b0;
    addr_o = 8'h00;
    dat_o  = 8'h00;
    dat_oe = 8'h00;
    rdata  = rdata_q;
    case (state_q)
      S_ADDR: begin
        addr_o = addr_byte;
        if (we_q) begin
          dat_o  = wdata_byte;
          dat_oe = 8'hFF;
        end
      end
      S_CMD: begin
        addr_o = {7'b0, we_q};
      end
      S_DATA: begin
        if (we_q) begin
          dat_o  = wdata_byte;
          dat_oe = 8'hFF;
        end
      end
      S_DONE: begin
        ack0 = ~gnt_q;
        ack1 = gnt_q;
      end
      default: begin
      end
    endcase
  end

  // Control state and read-data register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields; only observed outside IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter: directed and randomized bench for ext_bus_arbiter with a
// transaction-level reference model (arbitration rule plus per-beat schedule).
module tb_ext_bus_arbiter;

  localparam int A = 8;
  localparam int D = 8;

  localparam int K_ADDR  = 0;
  localparam int K_CMD   = 1;
  localparam int K_DATA  = 2;
  localparam int K_STALL = 3;
  localparam int K_ACK   = 4;

  typedef struct {
    int kind;
    int beat;
  } slot_t;

  logic           clk;
  logic           rst;
  logic           req0, req1, we0, we1;
  logic [8*A-1:0] addr0, addr1;
  logic [8*D-1:0] wdata0, wdata1;
  logic           ack0, ack1, busy;
  logic [8*D-1:0] rdata;
  logic [7:0]     addr_o, dat_o, dat_oe, dat_i;
`ifdef EXT_BUS_WAIT_EN
  logic           bus_wait;
`endif
  logic [26:0]    pins;

  int checks   = 0;
  int failures = 0;

  bit             m_last;
  logic [8*D-1:0] m_rdata;

  ext_bus_arbiter #(.ADDR_BYTES(A), .DATA_BYTES(D)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .addr_o(addr_o), .dat_o(dat_o), .dat_oe(dat_oe), .dat_i(dat_i)
`ifdef EXT_BUS_WAIT_EN
    , .bus_wait(bus_wait)
`endif
  );

  assign pins = {busy, ack0, ack1, addr_o, dat_o, dat_oe};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields();
    we0    = 1'($urandom);
    we1    = 1'($urandom);
    addr0  = {$urandom, $urandom};
    addr1  = {$urandom, $urandom};
    wdata0 = {$urandom, $urandom};
    wdata1 = {$urandom, $urandom};
  endtask

  // Called in an IDLE cycle with requests already presented. Checks every
  // cycle through the ack and returns in the IDLE cycle that follows it.
  task automatic run_txn(input string name, input bit ramp, input bit rerand,
                         input int drop_off, input int abort_off,
                         input int stall_beat, input int stall_len);
    bit             w, twe, eack0, eack1;
    logic [8*A-1:0] taddr;
    logic [8*D-1:0] twd;
    logic [7:0]     ea, ed, eo;
    slot_t          sq[$];
    slot_t          s;
    check({name, " idle"}, 64'(pins), 64'd0);
    if (req0 && req1) w = ~m_last;
    else w = req1;
    m_last = w;
    twe   = w ? we1 : we0;
    taddr = w ? addr1 : addr0;
    twd   = w ? wdata1 : wdata0;
    for (int k = 0; k < A; k++) sq.push_back('{K_ADDR, k});
    sq.push_back('{K_CMD, 0});
    for (int k = 0; k < D; k++) begin
      if (k == stall_beat)
        for (int r = 0; r < stall_len; r++) sq.push_back('{K_STALL, k});
      sq.push_back('{K_DATA, k});
    end
    sq.push_back('{K_ACK, 0});
    tick();
    for (int i = 0; i < sq.size(); i++) begin
      s = sq[i];
      if (s.kind == K_STALL || !ramp) dat_i = 8'($urandom);
      else dat_i = 8'(8'h10 + s.beat);
`ifdef EXT_BUS_WAIT_EN
      bus_wait = (s.kind == K_STALL);
`endif
      if (rerand) rand_fields();
      if (i + 1 == drop_off) begin
        if (w) req1 = 1'b0;
        else req0 = 1'b0;
      end
      ea = 8'h00; ed = 8'h00; eo = 8'h00; eack0 = 1'b0; eack1 = 1'b0;
      case (s.kind)
        K_ADDR: begin
          ea = taddr[8*s.beat +: 8];
          if (twe) begin
            ed = (s.beat < D) ? twd[8*s.beat +: 8] : 8'h00;
            eo = 8'hFF;
          end
        end
        K_CMD: ea = {7'b0, twe};
        K_DATA, K_STALL: begin
          if (twe) begin
            ed = twd[8*s.beat +: 8];
            eo = 8'hFF;
          end
        end
        default: begin
          eack0 = ~w;
          eack1 = w;
        end
      endcase
      check($sformatf("%s pins off%0d", name, i + 1), 64'(pins),
            64'({1'b1, eack0, eack1, ea, ed, eo}));
      if (s.kind == K_ACK) check({name, " rdata"}, 64'(rdata), 64'(m_rdata));
      if (s.kind == K_DATA && !twe) m_rdata[8*s.beat +: 8] = dat_i;
      if (i + 1 == abort_off) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last  = 1'b1;
        m_rdata = '0;
        check({name, " abort pins"}, 64'(pins), 64'd0);
        check({name, " abort rdata"}, 64'(rdata), 64'd0);
        return;
      end
      tick();
    end
`ifdef EXT_BUS_WAIT_EN
    bus_wait = 1'b0;
`endif
  endtask

  initial begin
    int p;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    dat_i = 8'h00;
`ifdef EXT_BUS_WAIT_EN
    bus_wait = 1'b0;
`endif
    rand_fields();
    m_last  = 1'b1;
    m_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset pins", 64'(pins), 64'd0);
    check("reset rdata", 64'(rdata), 64'd0);

    // Single read by requester 0 with dat_i = 10h+k
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h0123_4567_89AB_CDEF;
    run_txn("read0", 1'b1, 1'b0, 0, 0, -1, 0);
    req0 = 1'b0;
    check("read0 value", 64'(rdata), 64'h1716_1514_1312_1110);
    tick();

    // Single write by requester 1; rdata must not change
    req1 = 1'b1; we1 = 1'b1; wdata1 = 64'hA5A5_0000_FFFF_1234;
    run_txn("write1", 1'b0, 1'b0, 0, 0, -1, 0);
    req1 = 1'b0;
    check("write1 rdata kept", 64'(rdata), 64'h1716_1514_1312_1110);
    tick();

    // Contention held across four transactions, fields scrambled mid-flight
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 4; n++) run_txn($sformatf("rr%0d", n), 1'b0, 1'b1, 0, 0, -1, 0);

    // Random back-to-back request patterns
    for (int n = 0; n < 6; n++) begin
      p = $urandom_range(1, 3);
      req0 = p[0]; req1 = p[1];
      rand_fields();
      run_txn($sformatf("rnd%0d", n), 1'b0, 1'b0, 0, 0, -1, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Requester 0 drops its request in ADDR beat 2
    req0 = 1'b1; rand_fields();
    run_txn("drop0", 1'b0, 1'b0, 3, 0, -1, 0);
    tick();
    check("drop0 no repeat", 64'(pins), 64'd0);

    // Reset in DATA beat 3 of a read
    req0 = 1'b1; we0 = 1'b0;
    run_txn("abort", 1'b0, 1'b0, 0, A + 5, -1, 0);
    req0 = 1'b0;
    tick();
    check("abort stays idle", 64'(pins), 64'd0);

    // Pointer is back to 1 after reset, so requester 0 wins contention
    req0 = 1'b1; req1 = 1'b1; rand_fields();
    run_txn("post_rst_rr", 1'b0, 1'b0, 0, 0, -1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();

`ifdef EXT_BUS_WAIT_EN
    // Three wait cycles on DATA beat 5 of a read
    req1 = 1'b1; we1 = 1'b0;
    run_txn("wait", 1'b1, 1'b0, 0, 0, 5, 3);
    req1 = 1'b0;
    check("wait byte5", 64'(rdata[47:40]), 64'h15);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
